// File: rtl/ipml_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ipml_fifo_pkg                                                   |
// | Brief    : Shared helpers and parameter legality rules for the IPML FIFOs. |
// | Revision : 2.0                                                            |
// +----------------------------------------------------------------------------+
package ipml_fifo_pkg;

  localparam int c_MIN_DEPTH_WIDTH = 2;
  localparam int c_MAX_DEPTH_WIDTH = 16;
  localparam int c_MIN_DATA_WIDTH  = 1;
  localparam int c_MAX_DATA_WIDTH  = 1152;
  localparam int c_MIN_PREFETCH    = 2;
  localparam int c_MAX_PREFETCH    = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // The peak level (full RAM plus full prefetch buffer) must fit level_width bits.
  function automatic bit params_legal(input int depth_width, input int data_width,
                                      input int prefetch_depth);
    return (depth_width >= c_MIN_DEPTH_WIDTH) && (depth_width <= c_MAX_DEPTH_WIDTH) &&
           (data_width >= c_MIN_DATA_WIDTH) && (data_width <= c_MAX_DATA_WIDTH) &&
           (prefetch_depth >= c_MIN_PREFETCH) && (prefetch_depth <= c_MAX_PREFETCH) &&
           (((1 << depth_width) + prefetch_depth) < (1 << level_width(depth_width)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipml_reg_fifo_v2_0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ipml_reg_fifo_v2_0                                              |
// | Brief    : Small register FIFO (valid/ready both sides) used as prefetch.  |
// | Revision : 2.0                                                            |
// +----------------------------------------------------------------------------+
module ipml_reg_fifo_v2_0
  import ipml_fifo_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  localparam int                c_PW   = clog2(DEPTH);
  localparam logic [c_PW-1:0]   c_LAST = c_PW'(DEPTH - 1);
  localparam logic [c_PW-1:0]   c_ONE  = c_PW'(1);
  localparam logic [CW-1:0]     c_FULL = CW'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_PW-1:0] r_wp;
  logic [c_PW-1:0] r_rp;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign in_ready  = (r_cnt != c_FULL);
  assign out_valid = (r_cnt != '0);
  assign out_data  = r_mem[r_rp];
  assign count     = r_cnt;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= in_data;
        r_wp        <= (r_wp == c_LAST) ? '0 : r_wp + c_ONE;
      end
      if (w_pop) r_rp <= (r_rp == c_LAST) ? '0 : r_rp + c_ONE;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipml_prefetch_sync_fifo_v2_0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ipml_prefetch_sync_fifo_v2_0                                    |
// | Brief    : Single-clock show-ahead FIFO: inferred SDP RAM + prefetch regs. |
// |            IPML_FIFO_ERR_FLAG_EN enables sticky overflow/underflow flags.  |
// | Revision : 2.0                                                            |
// +----------------------------------------------------------------------------+
module ipml_prefetch_sync_fifo_v2_0
  import ipml_fifo_pkg::*;
#(
  parameter int c_DEPTH_WIDTH    = 10,
  parameter int c_DATA_WIDTH     = 32,
  parameter int c_PREFETCH_DEPTH = 2,
  parameter int c_AF_LEVEL       = 1020,
  parameter int c_AE_LEVEL       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [c_DATA_WIDTH-1:0] wr_data,
  input  logic                    wr_en,
  output logic                    wr_vld,
  output logic [c_DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_en,
  output logic                    rd_vld,
  output logic [c_DEPTH_WIDTH:0]  level,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int                       c_LW        = level_width(c_DEPTH_WIDTH);
  localparam int                       c_BUF_CW    = clog2(c_PREFETCH_DEPTH + 1);
  localparam logic [c_DEPTH_WIDTH:0]   c_RAM_WORDS = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
  localparam logic [c_DEPTH_WIDTH-1:0] c_PTR_ONE   = c_DEPTH_WIDTH'(1);

  if (!params_legal(c_DEPTH_WIDTH, c_DATA_WIDTH, c_PREFETCH_DEPTH)) begin : g_param_check
    $error("ipml_prefetch_sync_fifo_v2_0: illegal parameter combination");
  end

  logic [c_DATA_WIDTH-1:0]  r_ram [2**c_DEPTH_WIDTH];
  logic [c_DATA_WIDTH-1:0]  r_ram_q;
  logic [c_DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [c_LW-1:0]          r_ram_count;
  logic [c_LW-1:0]          w_ram_count_nxt;
  logic [c_LW-1:0]          r_level;
  logic [c_LW-1:0]          w_level_nxt;
  logic                     r_inflight;
  logic                     r_wr_vld;
  logic                     r_af;
  logic                     r_ae;
  logic                     w_wr_acc;
  logic                     w_pop;
  logic                     w_ram_rd;
  logic                     w_rd_vld;
  logic                     w_buf_in_ready;
  logic [c_BUF_CW-1:0]      w_buf_count;

  assign w_wr_acc = wr_en & r_wr_vld;
  assign w_pop    = rd_en & w_rd_vld;
  // Only fetch when the word is guaranteed a buffer slot on landing.
  assign w_ram_rd = (r_ram_count != '0) &&
                    ((int'(w_buf_count) + int'(r_inflight) - int'(w_pop)) < c_PREFETCH_DEPTH);

  assign w_ram_count_nxt = r_ram_count + c_LW'(w_wr_acc) - c_LW'(w_ram_rd);
  assign w_level_nxt     = r_level + c_LW'(w_wr_acc) - c_LW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_ram[r_wr_ptr] <= wr_data;
    if (w_ram_rd) r_ram_q <= r_ram[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_inflight  <= 1'b0;
      r_level     <= '0;
      r_wr_vld    <= 1'b1;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_ram_count <= w_ram_count_nxt;
      r_inflight  <= w_ram_rd;
      r_level     <= w_level_nxt;
      r_wr_vld    <= (w_ram_count_nxt != c_RAM_WORDS);
      r_af        <= (int'(w_level_nxt) >= c_AF_LEVEL);
      r_ae        <= (int'(w_level_nxt) <= c_AE_LEVEL);
      assert (!r_inflight || w_buf_in_ready);
    end
  end

  ipml_reg_fifo_v2_0 #(
    .W     (c_DATA_WIDTH),
    .DEPTH (c_PREFETCH_DEPTH),
    .CW    (c_BUF_CW)
  ) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_inflight),
    .in_ready  (w_buf_in_ready),
    .in_data   (r_ram_q),
    .out_valid (w_rd_vld),
    .out_ready (rd_en),
    .out_data  (rd_data),
    .count     (w_buf_count)
  );

  assign wr_vld       = r_wr_vld;
  assign rd_vld       = w_rd_vld;
  assign level        = r_level;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;

`ifdef IPML_FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & ~r_wr_vld) r_overflow <= 1'b1;
      if (rd_en & ~w_rd_vld) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ipml_prefetch_sync_fifo_v2_0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ipml_prefetch_sync_fifo_v2_0                                 |
// | Brief    : Randomised scoreboard bench for the show-ahead sync FIFO.       |
// | Revision : 2.0                                                            |
// +----------------------------------------------------------------------------+
module tb_ipml_prefetch_sync_fifo_v2_0;

  localparam int DW  = 10;
  localparam int W   = 32;
  localparam int PD  = 2;
  localparam int AF  = 1020;
  localparam int AE  = 4;
  localparam int CAP = (1 << DW) + PD;
`ifdef IPML_FIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_vld;
  logic [W-1:0]  rd_data;
  logic          rd_en = 1'b0;
  logic          rd_vld;
  logic [DW:0]   level;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  ipml_prefetch_sync_fifo_v2_0 #(
    .c_DEPTH_WIDTH    (DW),
    .c_DATA_WIDTH     (W),
    .c_PREFETCH_DEPTH (PD),
    .c_AF_LEVEL       (AF),
    .c_AE_LEVEL       (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_vld       (wr_vld),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_vld       (rd_vld),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference: an ordered queue of (word, write edge); a word is visible
  // at the head two edges after it was accepted.
  typedef struct {
    logic [W-1:0] d;
    int           t;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;
  int   n_pops   = 0;
  bit   ovf_m    = 1'b0;
  bit   udf_m    = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h edge=%0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic bit m_rd_vld();
    return (q.size() > 0) && (edge_n >= q[0].t + 2);
  endfunction

  function automatic bit m_wr_vld();
    return q.size() < CAP;
  endfunction

  task automatic check_outputs();
    check_val("wr_vld", wr_vld, m_wr_vld());
    check_val("rd_vld", rd_vld, m_rd_vld());
    if (m_rd_vld()) check_val("rd_data", rd_data, q[0].d);
    check_val("level", level, q.size());
    check_val("almost_full", almost_full, q.size() >= AF);
    check_val("almost_empty", almost_empty, q.size() <= AE);
    check_val("overflow", overflow, ERR_EN & ovf_m);
    check_val("underflow", underflow, ERR_EN & udf_m);
  endtask

  task automatic step(input bit we, input logic [W-1:0] wd, input bit re);
    bit acc_w;
    bit acc_r;
    acc_w = we && m_wr_vld();
    acc_r = re && m_rd_vld();
    if (we && !acc_w) ovf_m = 1'b1;
    if (re && !acc_r) udf_m = 1'b1;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    edge_n++;
    if (acc_r) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (acc_w) q.push_back(ent_t'{d: wd, t: edge_n});
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    edge_n = 0;
    #1;
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    check_outputs();
    check_val("rst_rd_data", rd_data, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < CAP + 8 && q.size() > 0; i++) step(1'b0, '0, 1'b1);
    check_val("drain_level", level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout edge=%0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: single write latency
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 32'hA5A5_0001, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("t1_rd_vld", rd_vld, 1);
    check_val("t1_rd_data", rd_data, 32'hA5A5_0001);
    check_val("t1_level", level, 1);

    // 2: fill to capacity, rejected writes, full + pop, drain
    do_reset();
    for (int i = 0; i < CAP; i++) step(1'b1, W'(32'h2000_0000 + i), 1'b0);
    check_val("t2_full", wr_vld, 0);
    check_val("t2_level", level, CAP);
    check_val("t2_af", almost_full, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD_BEEF, 1'b0);
    check_val("t2_overflow", overflow, ERR_EN);
    step(1'b1, 32'hBAD0_0000, 1'b1);
    check_val("t2_pop_reopen", wr_vld, 1);
    step(1'b1, 32'h2FFF_FFFF, 1'b0);
    drain();

    // 3: streaming
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 5000; i++) step(1'b1, W'(i), 1'b1);
    check_val("t3_pops", n_pops, 4997);
    check_val("t3_level", level, 3);
    drain();

    // 4: random traffic, balanced then write-heavy
    do_reset();
    for (int i = 0; i < 2000; i++)
      step($urandom_range(99) < 50, $urandom(), $urandom_range(99) < 50);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) < 70, $urandom(), $urandom_range(99) < 30);
    drain();

    // 5: reads on an empty FIFO
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check_val("t5_level", level, 0);
    check_val("t5_underflow", underflow, ERR_EN);

    // 6: reset with stored words and a RAM read in flight
    do_reset();
    for (int i = 0; i < 37; i++) step(1'b1, W'(32'h6000_0000 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    check_val("t6_rd_vld", rd_vld, 0);
    check_val("t6_level", level, 0);
    check_val("t6_wr_vld", wr_vld, 1);
    step(1'b1, 32'hC0DE_0006, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("t6_rd_data", rd_data, 32'hC0DE_0006);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
